// File: rtl/sub0_pipe.sv
// Two-stage pipelined subtractor (a_in - b_in) with parallel-prefix borrow chain and valid/ready I/O.
// Optional macro SUB0_SATURATE_EN: clamp diff to 0 on unsigned borrow.
module sub0_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int H = WIDTH / 2;

    // Kogge-Stone prefix over one half; bit k of the result is the carry into bit k+1.
    function automatic logic [H-1:0] prefix_carry(input logic [H-1:0] p,
                                                   input logic [H-1:0] g,
                                                   input logic         cin);
        logic [H-1:0] gg;
        logic [H-1:0] pp;
        logic [H-1:0] gn;
        logic [H-1:0] pn;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < H; d = d * 2) begin
            gn = gg;
            pn = pp;
            for (int i = d; i < H; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gg = gn;
            pp = pn;
        end
        return gg;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [H-1:0]     clo_q, clo_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [H-1:0]     chi_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] diff_raw_s;
    logic             borrow_raw_s;

    assign s2_adv_s = ~out_valid_q | out_ready;
    assign s1_adv_s = s1_valid_q & s2_adv_s;
    assign in_ready = ~s1_valid_q | s2_adv_s;
    assign accept_s = in_valid & in_ready;

    // Datapath: subtraction as a + ~b + 1, low-half carries in S1, high half in S2.
    always_comb begin
        p_s          = a_in ^ ~b_in;
        g_s          = a_in & ~b_in;
        chi_s        = prefix_carry(p_q[WIDTH-1:H], g_q[WIDTH-1:H], clo_q[H-1]);
        c_s          = {chi_s, clo_q, 1'b1};
        diff_raw_s   = p_q ^ c_s[WIDTH-1:0];
        borrow_raw_s = ~c_s[WIDTH];
    end

    // Stage 1 next state: load on accept, empty when handed to S2, else hold.
    always_comb begin
        p_d        = p_q;
        g_d        = g_q;
        clo_d      = clo_q;
        s1_valid_d = s1_valid_q;
        if (accept_s) begin
            p_d        = p_s;
            g_d        = g_s;
            clo_d      = prefix_carry(p_s[H-1:0], g_s[H-1:0], 1'b1);
            s1_valid_d = 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: results only change when the output slot can advance.
    always_comb begin
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef SUB0_SATURATE_EN
                diff_d = borrow_raw_s ? {WIDTH{1'b0}} : diff_raw_s;
`else
                diff_d = diff_raw_s;
`endif
                borrow_d = borrow_raw_s;
                ovf_d    = c_s[WIDTH] ^ c_s[WIDTH-1];
                zero_d   = (diff_raw_s == {WIDTH{1'b0}});
            end else begin
                diff_d   = diff_q;
                borrow_d = borrow_q;
                ovf_d    = ovf_q;
                zero_d   = zero_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1_valid_q  <= 1'b0;
            p_q         <= {WIDTH{1'b0}};
            g_q         <= {WIDTH{1'b0}};
            clo_q       <= {H{1'b0}};
            out_valid_q <= 1'b0;
            diff_q      <= {WIDTH{1'b0}};
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            clo_q       <= clo_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
